mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store sequencer between the execute stage and the byte-addressed 32-byte data memory `memory`.
- Accepts byte, halfword and word loads/stores over a req/ready/done handshake.
- Issues only aligned word accesses to the memory.
- Sub-word stores use a read-modify-write sequence; sub-word loads return a sign- or zero-extended lane.

Parameters:
- ADDR_W, 6, width of byte address on both sides.
- DEPTH_BYTES, 32, byte capacity of attached memory; used for range check.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req  in  1  request valid; held by requester until accepted.
- Ready  out  1  high only in IDLE; a request is accepted on an edge where Req&&Ready.
- Op_Store  in  1  1=store, 0=load.
- Size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- Signed  in  1  loads only: 1=sign-extend, 0=zero-extend.
- Addr  in  ADDR_W  byte address.
- W_Data  in  32  store data; sub-word stores use the low bits.
- Done  out  1  one-cycle completion pulse.
- R_Data  out  32  load result; valid when Done=1, held until next load Done.
- Err  out  1  valid with Done; constant 0 unless MISALIGN_TRAP_EN.
- Mem_Addr  out  ADDR_W  to memory; always {Addr[ADDR_W-1:2],2'b00}.
- M_W_Data  out  32  to memory write data.
- Mem_Read  out  1  to memory read enable.
- Mem_Write  out  1  to memory write enable; level-sensitive write at the memory.
- M_R_Data  in  32  from memory; combinational, valid in the same cycle as Mem_Read.

Behaviour:
- Reset: state=IDLE; Ready=1; all other outputs 0, including R_Data, Mem_Addr, M_W_Data and Mem_Read/Mem_Write.
- Reset mid-operation: abandons any in-flight access and returns to IDLE with no Done pulse. Memory is untouched if reset lands before WR.
- States: IDLE, RD, WR, RESP. All memory-side outputs are registered; no combinational path from inputs to memory.
- Lanes are little-endian: byte k = word[8k+7:8k]; half h = word[16h+15:16h].
- Byte offset = Addr[1:0]. Half uses Addr[1]; Addr[0] is ignored. Word ignores Addr[1:0].
- Accept at edge T:
  - Latch Op_Store, Size, Signed, offset, W_Data.
  - Drive Mem_Addr with the aligned address.
- Word store: T+1 WR (Mem_Write=1, M_W_Data=W_Data), T+2 RESP.
- Sub-word store:
  - T+1 RD: Mem_Read=1; capture M_R_Data at end of cycle.
  - T+2 WR: M_W_Data = captured word with the selected lane replaced by W_Data[7:0] or [15:0]; Mem_Write=1.
  - T+3 RESP.
- Load:
  - T+1 RD: capture the selected lane, extended per Signed, into R_Data.
  - T+2 RESP.
- RESP: Done=1 for exactly one cycle; Ready=0; Mem_Read=Mem_Write=0. Mem_Addr and M_W_Data hold their values from WR through RESP so the level-sensitive write cannot corrupt a neighbouring word.
- Mem_Read and Mem_Write are never both 1. Each is high for exactly one cycle per access.
- Busy handling: Req during RD/WR/RESP is ignored. The earliest next accept is the edge ending RESP+1 (IDLE).
- Peak throughput: one load or word store per 3 cycles; one sub-word store per 4 cycles.
- R_Data is unchanged by stores. Err=0 on every completion.

Optional Feature:
- MISALIGN_TRAP_EN defined — at accept, the request is flagged if any of these hold:
  - half with Addr[0]=1;
  - word or Size=11 with Addr[1:0]≠0;
  - Addr+access_bytes > DEPTH_BYTES.
- Flagged request handling: goes IDLE→RESP at T+1 with Done=1 and Err=1. No Mem_Read or Mem_Write; R_Data unchanged.
- Not defined: Err tied 0; low address bits are silently dropped as above; no range check.

Test Plan:
- Word store 0xDEADBEEF to addr 8, then word load addr 8 → Mem_Write exactly one cycle; Done at T+2 for both; R_Data=0xDEADBEEF.
- Memory addr 4 holds 0x11223344; byte store W_Data=0xAA at addr 6 → Mem_Read at T+1, Mem_Write at T+2 with M_W_Data=0x11AA3344, Done at T+3.
- Byte 0x80 at addr 1: load with Signed=1 → 0xFFFFFF80; Signed=0 → 0x00000080.
- Half store 0xBEEF at addr 14 over 0x00000000, then half load signed → word at 12 = 0xBEEF0000; R_Data=0xFFFFBEEF.
- Reset asserted during RD of a byte store to addr 4 → no Mem_Write ever issued, no Done, Ready=1 next cycle, addr 4 word unchanged.
- MISALIGN_TRAP_EN: word load addr 5 → Done+Err at T+1, Mem_Read never high. Without macro: same request reads aligned addr 4.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Load/store request bus plus the word-wide memory port of mem_access_unit.
// slave: the sequencer; master: the execute stage together with the memory.
interface mem_access_unit_if #(
  parameter int ADDR_W = 6
);
  logic              Req;
  logic              Ready;
  logic              Op_Store;
  logic [1:0]        Size;
  logic              Signed;
  logic [ADDR_W-1:0] Addr;
  logic [31:0]       W_Data;
  logic              Done;
  logic [31:0]       R_Data;
  logic              Err;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [31:0]       M_W_Data;
  logic              Mem_Read;
  logic              Mem_Write;
  logic [31:0]       M_R_Data;

  modport slave (
    input  Req, Op_Store, Size, Signed, Addr, W_Data, M_R_Data,
    output Ready, Done, R_Data, Err, Mem_Addr, M_W_Data, Mem_Read, Mem_Write
  );

  modport master (
    output Req, Op_Store, Size, Signed, Addr, W_Data, M_R_Data,
    input  Ready, Done, R_Data, Err, Mem_Addr, M_W_Data, Mem_Read, Mem_Write
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store sequencer issuing only aligned word accesses; sub-word stores are read-modify-write.
// Optional MISALIGN_TRAP_EN: misaligned or out-of-range requests complete at once with Err=1 and no memory access.
module mem_access_unit #(
  parameter int ADDR_W      = 6,
  parameter int DEPTH_BYTES = 32
) (
  input logic              CLK,
  input logic              Reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_BYTES);

`ifdef MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  state_t            state_q, state_d;
  logic              store_q, store_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdat_q, wdat_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       mwdat_q, mwdat_d;
  logic              mrd_q, mrd_d;
  logic              mwr_q, mwr_d;

  logic [ADDR_W:0]   acc_bytes;
  logic [ADDR_W:0]   end_addr;
  logic              misalign;
  logic              out_of_range;
  logic              flag;
  logic              is_word_req;

  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [15:0] wdat,
                                             input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = word;
    if (size == SZ_BYTE) r[{off, 3'b000} +: 8] = wdat[7:0];
    else                 r[{off[1], 4'b0000} +: 16] = wdat;
    return r;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word;
    r  = word;
    if (size == SZ_BYTE) begin
      sh = word >> {off, 3'b000};
      r  = {{24{sgn & sh[7]}}, sh[7:0]};
    end else if (size == SZ_HALF) begin
      sh = word >> {off[1], 4'b0000};
      r  = {{16{sgn & sh[15]}}, sh[15:0]};
    end
    return r;
  endfunction

  always_comb begin
    acc_bytes = (ADDR_W+1)'(4);
    case (bus.Size)
      SZ_BYTE: acc_bytes = (ADDR_W+1)'(1);
      SZ_HALF: acc_bytes = (ADDR_W+1)'(2);
      default: acc_bytes = (ADDR_W+1)'(4);
    endcase
  end

  // Trap qualification is always computed; it only takes effect when TRAP_EN is set.
  assign end_addr     = {1'b0, bus.Addr} + acc_bytes;
  assign misalign     = ((bus.Size == SZ_HALF) && bus.Addr[0]) ||
                        (bus.Size[1] && (bus.Addr[1:0] != 2'b00));
  assign out_of_range = end_addr > DEPTH_L;
  assign flag         = TRAP_EN && (misalign || out_of_range);
  assign is_word_req  = bus.Size[1];

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    off_d   = off_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    maddr_d = maddr_q;
    mwdat_d = mwdat_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mrd_d   = 1'b0;
    mwr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.Req && ready_q) begin
          store_d = bus.Op_Store;
          size_d  = bus.Size;
          sgn_d   = bus.Signed;
          off_d   = bus.Addr[1:0];
          wdat_d  = bus.W_Data;
          maddr_d = {bus.Addr[ADDR_W-1:2], 2'b00};
          if (flag) begin
            state_d = RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (bus.Op_Store && is_word_req) begin
            state_d = WR;
            mwr_d   = 1'b1;
            mwdat_d = bus.W_Data;
          end else begin
            state_d = RD;
            mrd_d   = 1'b1;
          end
        end
      end
      RD: begin
        if (store_q) begin
          state_d = WR;
          mwr_d   = 1'b1;
          mwdat_d = lane_merge(bus.M_R_Data, wdat_q[15:0], size_q, off_q);
        end else begin
          state_d = RESP;
          done_d  = 1'b1;
          rdata_d = lane_extract(bus.M_R_Data, size_q, off_q, sgn_q);
        end
      end
      WR: begin
        state_d = RESP;
        done_d  = 1'b1;
      end
      RESP: begin
        // Mem_Addr/M_W_Data stay put so the level-sensitive write has nothing to glitch onto.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      off_q   <= 2'b00;
      wdat_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      maddr_q <= '0;
      mwdat_q <= '0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      off_q   <= off_d;
      wdat_q  <= wdat_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      maddr_q <= maddr_d;
      mwdat_q <= mwdat_d;
      mrd_q   <= mrd_d;
      mwr_q   <= mwr_d;
    end
  end

  assign bus.Ready     = ready_q;
  assign bus.Done      = done_q;
  assign bus.Err       = err_q;
  assign bus.R_Data    = rdata_q;
  assign bus.Mem_Addr  = maddr_q;
  assign bus.M_W_Data  = mwdat_q;
  assign bus.Mem_Read  = mrd_q;
  assign bus.Mem_Write = mwr_q;

endmodule
